// File: rtl/secure_proc_pkg.sv
// Shared encodings for the secure processor command master.
package secure_proc_pkg;

  // Processor command codes
  localparam logic [3:0] CMD_IDLE  = 4'b0000;
  localparam logic [3:0] CMD_WR    = 4'b0001;
  localparam logic [3:0] CMD_RD    = 4'b0010;
  localparam logic [3:0] CMD_XOR   = 4'b0011;
  localparam logic [3:0] CMD_RDTMP = 4'b0100;

  // Host op encodings; 2'd3 is reserved and answered with an error
  localparam logic [1:0] OP_WRITE    = 2'd0;
  localparam logic [1:0] OP_READ     = 2'd1;
  localparam logic [1:0] OP_SCRAMBLE = 2'd2;

  // Processor scramble key; only the bench's processor model uses it
  localparam logic [31:0] PROC_RESET_KEY = 32'hDEADBEEF;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StTmp,
    StCapture,
    StResp
  } state_e;

endpackage

// File: rtl/secure_dbg_gate.sv
// Registered debug mask: forwards processor debug data only while unlocked.
module secure_dbg_gate #(
  parameter int unsigned DataW = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             unlock_i,
  input  logic [DataW-1:0] data_i,
  output logic [DataW-1:0] data_o
);

  logic [DataW-1:0] data_q;

  // Register the masked view so nothing combinational leaks the internal register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else begin
      data_q <= unlock_i ? data_i : '0;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/secure_proc_cmd_master.sv
// Host-side initiator that sequences commands on the secure processor interface.
module secure_proc_cmd_master
  import secure_proc_pkg::*;
#(
  parameter int unsigned DataW = 32,
  parameter int unsigned CmdW  = 4,
  parameter int unsigned CntW  = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [DataW-1:0] req_data_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [DataW-1:0] rsp_data_o,
  output logic             rsp_err_o,
  output logic [CmdW-1:0]  proc_cmd_o,
  output logic [DataW-1:0] proc_data_in_o,
  input  logic [DataW-1:0] proc_data_out_i,
  input  logic [DataW-1:0] proc_debug_data_i,
  input  logic             dbg_unlock_i,
  output logic [DataW-1:0] dbg_data_o,
  output logic [CntW-1:0]  txn_count_o
);

  state_e           state_q;
  logic [1:0]       op_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [DataW-1:0] rsp_data_q;
  logic             rsp_err_q;
  logic [CmdW-1:0]  proc_cmd_q;
  logic [DataW-1:0] proc_data_in_q;
  logic [CntW-1:0]  txn_count_q;

  // Single FSM; every output is loaded on the edge that enters the cycle it belongs to
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      op_q           <= OP_WRITE;
      req_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_err_q      <= 1'b0;
      proc_cmd_q     <= CmdW'(CMD_IDLE);
      proc_data_in_q <= '0;
      txn_count_q    <= '0;
    end else begin
      proc_cmd_q <= CmdW'(CMD_IDLE);
      unique case (state_q)
        StIdle: begin
          if (req_valid_i && req_ready_q) begin
            op_q           <= req_op_i;
            proc_data_in_q <= req_data_i;
            req_ready_q    <= 1'b0;
            rsp_data_q     <= '0;
            rsp_err_q      <= 1'b0;
            case (req_op_i)
              OP_WRITE: begin
                state_q    <= StIssue;
                proc_cmd_q <= CmdW'(CMD_WR);
              end
              OP_READ: begin
                state_q    <= StIssue;
                proc_cmd_q <= CmdW'(CMD_RD);
              end
              OP_SCRAMBLE: begin
                state_q    <= StIssue;
                proc_cmd_q <= CmdW'(CMD_XOR);
              end
              default: begin
                // Reserved op: answer immediately, never touch the processor
                state_q     <= StResp;
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= 1'b1;
              end
            endcase
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        StIssue: begin
          case (op_q)
            OP_READ: state_q <= StCapture;
            OP_SCRAMBLE: begin
              state_q    <= StTmp;
              proc_cmd_q <= CmdW'(CMD_RDTMP);
            end
            default: begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
            end
          endcase
        end
        StTmp: begin
          state_q <= StCapture;
        end
        StCapture: begin
          // data_out was registered by the processor on the previous edge
          rsp_data_q  <= proc_data_out_i;
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (rsp_ready_i) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            txn_count_q <= txn_count_q + CntW'(1);
          end
        end
        default: begin
          state_q     <= StIdle;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  secure_dbg_gate #(
    .DataW(DataW)
  ) u_dbg_gate (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .unlock_i(dbg_unlock_i),
    .data_i  (proc_debug_data_i),
    .data_o  (dbg_data_o)
  );

  assign req_ready_o    = req_ready_q;
  assign rsp_valid_o    = rsp_valid_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_err_o      = rsp_err_q;
  assign proc_cmd_o     = proc_cmd_q;
  assign proc_data_in_o = proc_data_in_q;
  assign txn_count_o    = txn_count_q;

endmodule

// File: tb/tb_secure_proc_cmd_master.sv
// Directed bench for secure_proc_cmd_master with a behavioural processor model.
module tb_secure_proc_cmd_master;
  import secure_proc_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [31:0] req_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [3:0]  proc_cmd;
  logic [31:0] proc_data_in;
  logic [31:0] proc_data_out;
  logic [31:0] proc_debug_data;
  logic        dbg_unlock = 1'b0;
  logic [31:0] dbg_data;
  logic [15:0] txn_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  secure_proc_cmd_master dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_op_i         (req_op),
    .req_data_i       (req_data),
    .rsp_valid_o      (rsp_valid),
    .rsp_ready_i      (rsp_ready),
    .rsp_data_o       (rsp_data),
    .rsp_err_o        (rsp_err),
    .proc_cmd_o       (proc_cmd),
    .proc_data_in_o   (proc_data_in),
    .proc_data_out_i  (proc_data_out),
    .proc_debug_data_i(proc_debug_data),
    .dbg_unlock_i     (dbg_unlock),
    .dbg_data_o       (dbg_data),
    .txn_count_o      (txn_count)
  );

  // Processor model: internal reg, scramble temp, registered data_out
  logic [31:0] p_reg, p_tmp, p_out;
  always @(posedge clk) begin
    if (!rst_n) begin
      p_reg <= '0;
      p_tmp <= '0;
      p_out <= '0;
    end else begin
      case (proc_cmd)
        CMD_WR:    p_reg <= proc_data_in;
        CMD_RD:    p_out <= p_reg;
        CMD_XOR:   p_tmp <= p_reg ^ PROC_RESET_KEY;
        CMD_RDTMP: p_out <= p_tmp;
        default:   p_out <= '0;
      endcase
    end
  end
  assign proc_data_out   = p_out;
  assign proc_debug_data = p_reg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [3:0]  cmd0;
    logic [31:0] exp_data;
    logic        exp_err;
    int          lat;
  } vec_t;

  localparam int NVEC = 9;
  vec_t vecs[NVEC];

  // One full host transaction: accept, measure latency, check response, handshake
  task automatic do_txn(input vec_t v, input int idx);
    int w;
    int lat;
    logic [3:0] cmd0;
    logic [31:0] din0;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("v%0d_ready", idx), {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_op    = v.op;
    req_data  = v.data;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat  = 0;
    cmd0 = 4'hF;
    din0 = '0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        cmd0 = proc_cmd;
        din0 = proc_data_in;
      end
    end while (!rsp_valid && lat < 20);
    chk($sformatf("v%0d_cmd0", idx), {28'd0, cmd0}, {28'd0, v.cmd0});
    if (v.op == OP_WRITE) chk($sformatf("v%0d_din", idx), din0, v.data);
    chk($sformatf("v%0d_latency", idx), lat, v.lat);
    chk($sformatf("v%0d_rsp_data", idx), rsp_data, v.exp_data);
    chk($sformatf("v%0d_rsp_err", idx), {31'd0, rsp_err}, {31'd0, v.exp_err});
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{OP_WRITE,    32'h12345678, CMD_WR,   32'h0,        1'b0, 2};
    vecs[1] = '{OP_READ,     32'h0,        CMD_RD,   32'h12345678, 1'b0, 3};
    vecs[2] = '{OP_SCRAMBLE, 32'h0,        CMD_XOR,  32'hCC99E897, 1'b0, 4};
    vecs[3] = '{2'd3,        32'hFFFFFFFF, CMD_IDLE, 32'h0,        1'b1, 1};
    vecs[4] = '{OP_WRITE,    32'hA5A5A5A5, CMD_WR,   32'h0,        1'b0, 2};
    vecs[5] = '{OP_READ,     32'h0,        CMD_RD,   32'hA5A5A5A5, 1'b0, 3};
    vecs[6] = '{OP_SCRAMBLE, 32'h0,        CMD_XOR,  32'h7B081B4A, 1'b0, 4};
    vecs[7] = '{OP_WRITE,    32'h00000000, CMD_WR,   32'h0,        1'b0, 2};
    vecs[8] = '{OP_READ,     32'h0,        CMD_RD,   32'h00000000, 1'b0, 3};

    // Reset with a pending request
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_op    = OP_WRITE;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_proc_cmd", {28'd0, proc_cmd}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_dbg_data", dbg_data, 32'd0);
    chk("rst_txn_count", {16'd0, txn_count}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b0;

    // Table of transactions
    for (int i = 0; i < NVEC; i++) begin
      do_txn(vecs[i], i);
      if (i == 1) chk("txn_after_wr_rd", {16'd0, txn_count}, 32'd2);
    end
    chk("txn_after_table", {16'd0, txn_count}, NVEC);

    // Scramble command sequence after a fresh write
    do_txn(vecs[0], 100);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = OP_SCRAMBLE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("scr_seq0", {28'd0, proc_cmd}, {28'd0, CMD_XOR});
    @(negedge clk);
    chk("scr_seq1", {28'd0, proc_cmd}, {28'd0, CMD_RDTMP});
    @(negedge clk);
    chk("scr_seq2", {28'd0, proc_cmd}, {28'd0, CMD_IDLE});
    @(negedge clk);
    chk("scr_valid", {31'd0, rsp_valid}, 32'd1);
    chk("scr_data", rsp_data, 32'hCC99E897);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;

    // Reserved op under backpressure
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_valid", c), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("bp%0d_err", c), {31'd0, rsp_err}, 32'd1);
      chk($sformatf("bp%0d_cmd", c), {28'd0, proc_cmd}, 32'd0);
      chk($sformatf("bp%0d_ready", c), {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_release_valid", {31'd0, rsp_valid}, 32'd0);
    chk("bp_release_ready", {31'd0, req_ready}, 32'd1);

    // Debug gating
    do_txn(vecs[4], 200);
    @(negedge clk);
    chk("dbg_locked", dbg_data, 32'd0);
    dbg_unlock = 1'b1;
    @(negedge clk);
    chk("dbg_unlocked", dbg_data, 32'hA5A5A5A5);
    dbg_unlock = 1'b0;
    @(negedge clk);
    chk("dbg_relocked", dbg_data, 32'd0);

    // Reset during the TMP cycle of a scramble
    req_valid = 1'b1;
    req_op    = OP_SCRAMBLE;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_tmp_cmd", {28'd0, proc_cmd}, {28'd0, CMD_RDTMP});
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_cmd", {28'd0, proc_cmd}, 32'd0);
    chk("mid_txn", {16'd0, txn_count}, 32'd0);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (rsp_valid) seen++;
      end
      chk("mid_no_rsp", seen, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/secure_proc_cmd_master.md
Name: secure_proc_cmd_master

Overview:
Initiator for the secure processor's 4-bit command interface. It converts host requests (valid/ready) into correctly timed cmd/data_in sequences, captures the registered data_out, and returns responses (valid/ready). It also owns the processor's debug_data output and forwards it only while debug is unlocked, so the internal register is not visible on an unsafe debug path.

Parameters:
DATA_W, 32, width of the data path, processor data_in/data_out and debug_data
CMD_W, 4, width of the processor command bus
CNT_W, 16, width of the completed-transaction counter

Ports:
clk  input  1  single clock; all logic rises on posedge
rst_n  input  1  synchronous, active-low reset
req_valid  input  1  host request valid
req_ready  output  1  block can accept a request
req_op  input  2  0=WRITE, 1=READ, 2=SCRAMBLE, 3=reserved
req_data  input  DATA_W  write data; used for WRITE only
rsp_valid  output  1  response valid
rsp_ready  input  1  host accepts the response
rsp_data  output  DATA_W  read or scramble result; 0 for WRITE and errors
rsp_err  output  1  request used a reserved op
proc_cmd  output  CMD_W  drives processor cmd; registered
proc_data_in  output  DATA_W  drives processor data_in; registered
proc_data_out  input  DATA_W  processor data_out; registered inside the processor
proc_debug_data  input  DATA_W  processor debug_data
dbg_unlock  input  1  debug access permitted
dbg_data  output  DATA_W  gated debug view; registered
txn_count  output  CNT_W  number of completed responses; wraps

Behaviour:
- Processor command codes: IDLE=4'b0000, WR=4'b0001, RD=4'b0010, XOR=4'b0011, RDTMP=4'b0100. Any cmd that is not WR/RD/XOR/RDTMP clears processor data_out at the next edge. proc_cmd is IDLE in every cycle not listed below.
- Reset (rst_n=0 at a posedge, including mid-transaction): state=IDLE, proc_cmd=IDLE, proc_data_in=0, rsp_valid=0, rsp_data=0, rsp_err=0, dbg_data=0, txn_count=0. An in-flight transaction is dropped and no response is produced.
- req_ready=1 only in IDLE. A request is accepted at a posedge where req_valid and req_ready are both 1. The op and data are latched at that edge.
- FSM states: IDLE, ISSUE, TMP, CAPTURE, RESP.
- IDLE -> ISSUE on accept of WRITE, READ or SCRAMBLE. IDLE -> RESP on accept of op 3, with rsp_err=1 and rsp_data=0. No processor command is issued for op 3.
- ISSUE drives one cycle of WR (proc_data_in = latched data), RD, or XOR:
  - WRITE: next state RESP, rsp_data=0.
  - READ: next state CAPTURE.
  - SCRAMBLE: next state TMP.
- TMP drives RDTMP for one cycle, then goes to CAPTURE.
- CAPTURE drives IDLE. At the end of this cycle it samples proc_data_out into rsp_data, then goes to RESP. The sampled value is the one the processor registered on the previous edge.
- RESP: rsp_valid=1, and rsp_data/rsp_err are held stable until rsp_ready=1. On the handshake edge: state=IDLE, rsp_valid=0, txn_count++ (modulo 2^CNT_W).
- Latency from accept edge to first rsp_valid cycle: WRITE 2 cycles, READ 3, SCRAMBLE 4, reserved op 1. A new request is accepted no earlier than the cycle after the response handshake, so there is no overlap.
- Debug gate: dbg_data <= dbg_unlock ? proc_debug_data : 0 every cycle (1-cycle latency). Dropping dbg_unlock zeroes dbg_data on the next edge.
- req_valid is ignored outside IDLE. rsp_ready is ignored outside RESP.

Decomposition:
- Shared package secure_proc_pkg holds:
  - CMD_* constants and the host op encodings OP_WRITE/OP_READ/OP_SCRAMBLE.
  - The FSM state enum.
  - The processor reset key value (32'hDEADBEEF), for benches only.
- One natural sub-module: secure_dbg_gate, the registered debug-masking stage. The rest stays flat.

Test Plan:
- Reset behaviour: hold rst_n=0 for 3 cycles with req_valid=1 -> req_ready=0, proc_cmd=0, rsp_valid=0, dbg_data=0, txn_count=0. Release rst_n -> req_ready=1 in the next cycle.
- Write then read: WRITE 0x12345678 -> proc_cmd=0001 with proc_data_in=0x12345678 for exactly one cycle, rsp_valid after 2 cycles with rsp_data=0. Then READ -> rsp_data=0x12345678, rsp_err=0, txn_count=2.
- Scramble after reset: write 0x12345678, then SCRAMBLE -> proc_cmd sequence 0011, 0100, 0000; rsp_data=0xCC99E897.
- Reserved op and backpressure: req_op=3 with rsp_ready held 0 for 5 cycles -> rsp_valid=1 and rsp_err=1 stay stable, proc_cmd stays 0, req_ready stays 0. Assert rsp_ready -> IDLE next cycle.
- Reset mid-transaction: assert rst_n=0 in the TMP cycle of a SCRAMBLE -> no response appears, proc_cmd=0 next cycle, txn_count=0.
- Debug gating: processor internal reg = 0xA5A5A5A5. dbg_unlock=0 -> dbg_data=0. Raise dbg_unlock -> dbg_data=0xA5A5A5A5 one cycle later. Drop dbg_unlock -> dbg_data=0 one cycle later.
